// File: rtl/ram_rr_arbiter_pkg.sv
// Shared definitions for the round-robin RAM access controller:
// op encoding and the index-width helper.
package ram_rr_arbiter_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/ram_rr_arbiter_rr_arb.sv
// Rotating-priority arbiter: client ptr wins first, then ptr+1, ... modulo NCLI.
// Emits a one-hot grant, its encoded index and a grant-valid flag.
module ram_rr_arbiter_rr_arb
    import ram_rr_arbiter_pkg::*;
#(
    parameter int NCLI = 4,
    parameter int IDW  = clog2(NCLI)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCLI-1:0] req,
    output logic [NCLI-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            vld
);

    logic [IDW-1:0] ptr;

    always_comb begin
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < NCLI; i++) begin
            c = (int'(ptr) + i) % NCLI;
            if (!vld && !rst && req[c]) begin
                gnt[c] = 1'b1;
                idx    = IDW'(c);
                vld    = 1'b1;
            end
        end
    end

    // Explicit wrap so non-power-of-2 client counts never reach an idle index
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (vld) begin
            ptr <= (int'(idx) == NCLI - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one 1W/1R registered-read RAM among NCLI clients, one op per cycle,
// driving RAM pins from registers and tagging read returns with the client index.
module ram_rr_arbiter
    import ram_rr_arbiter_pkg::*;
#(
    parameter int NCLI = 4,
    parameter int WI   = 8,
    parameter int DEP  = 16,
    parameter int ADD  = 4,
    parameter int IDW  = clog2(NCLI)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCLI-1:0]     req,
    input  logic [NCLI-1:0]     we,
    input  logic [NCLI*ADD-1:0] addr,
    input  logic [NCLI*WI-1:0]  wdata,
    output logic [NCLI-1:0]     gnt,
    output logic                rvalid,
    output logic [IDW-1:0]      rid,
    output logic [WI-1:0]       rdata,
    output logic                ram_wr,
    output logic                ram_rd,
    output logic [ADD-1:0]      ram_wa,
    output logic [ADD-1:0]      ram_ra,
    output logic [WI-1:0]       ram_din,
    input  logic [WI-1:0]       ram_dout
);

    if (DEP != (1 << ADD)) begin : g_dep_check
        $error("ram_rr_arbiter: DEP must equal 2**ADD");
    end

    logic [IDW-1:0] idx_p0;
    logic           vld_p0;
    logic           op_p0;
    logic [ADD-1:0] addr_p0;
    logic [WI-1:0]  wdata_p0;
    logic [IDW-1:0] tag_p1;

    ram_rr_arbiter_rr_arb #(
        .NCLI (NCLI),
        .IDW  (IDW)
    ) u_rr_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt),
        .idx (idx_p0),
        .vld (vld_p0)
    );

    assign op_p0    = we[idx_p0];
    assign addr_p0  = addr[int'(idx_p0)*ADD +: ADD];
    assign wdata_p0 = wdata[int'(idx_p0)*WI +: WI];

    // p0 -> p1: grant registered onto the RAM pins; read tag enters the pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wr  <= 1'b0;
            ram_rd  <= 1'b0;
            ram_wa  <= '0;
            ram_ra  <= '0;
            ram_din <= '0;
            tag_p1  <= '0;
        end else begin
            ram_wr <= vld_p0 && (op_p0 == OP_WR);
            ram_rd <= vld_p0 && (op_p0 == OP_RD);
            if (vld_p0 && (op_p0 == OP_WR)) begin
                ram_wa  <= addr_p0;
                ram_din <= wdata_p0;
            end
            if (vld_p0 && (op_p0 == OP_RD)) begin
                ram_ra <= addr_p0;
                tag_p1 <= idx_p0;
            end
        end
    end

    // p1 -> p2: RAM output register and the tag arrive together
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rid    <= '0;
        end else begin
            rvalid <= ram_rd;
            if (ram_rd) begin
                rid <= tag_p1;
            end
        end
    end

    assign rdata = ram_dout;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: RAM model, directed scenarios with literal
// expectations, and randomized traffic checked against a transaction-level model.
module tb_ram_rr_arbiter;

    localparam int NCLI = 4;
    localparam int WI   = 8;
    localparam int DEP  = 16;
    localparam int ADD  = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCLI-1:0]     req;
    logic [NCLI-1:0]     we;
    logic [NCLI*ADD-1:0] addr;
    logic [NCLI*WI-1:0]  wdata;
    logic [NCLI-1:0]     gnt;
    logic                rvalid;
    logic [IDW-1:0]      rid;
    logic [WI-1:0]       rdata;
    logic                ram_wr, ram_rd;
    logic [ADD-1:0]      ram_wa, ram_ra;
    logic [WI-1:0]       ram_din;
    logic [WI-1:0]       ram_dout;

    int n_chk  = 0;
    int n_fail = 0;
    int cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    ram_rr_arbiter #(.NCLI(NCLI), .WI(WI), .DEP(DEP), .ADD(ADD), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_wa(ram_wa), .ram_ra(ram_ra),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM instance model: 1W/1R, registered read, synchronous clear
    logic [WI-1:0] ram_mem [DEP];
    logic [WI-1:0] ram_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEP; i++) ram_mem[i] <= '0;
            ram_q <= '0;
        end else begin
            if (ram_wr) ram_mem[ram_wa] <= ram_din;
            if (ram_rd) ram_q <= ram_mem[ram_ra];
        end
    end
    assign ram_dout = ram_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cycle, act, exp);
        end
    endtask

    // Transaction-level reference: grant order, memory contents, pending returns
    typedef struct {
        int            due;
        int            id;
        logic [WI-1:0] data;
    } rd_t;

    rd_t           rq[$];
    logic [WI-1:0] mmem [DEP];
    int            mptr = 0;
    logic          e_wr = 0, e_rd = 0;
    logic [ADD-1:0] e_wa = 0, e_ra = 0;
    logic [WI-1:0]  e_din = 0;

    always @(negedge clk) begin
        int gk;
        int c;
        logic [NCLI-1:0] eg;
        logic ev;
        chk("ram_wr", ram_wr, e_wr);
        chk("ram_rd", ram_rd, e_rd);
        chk("ram_wa", ram_wa, e_wa);
        chk("ram_ra", ram_ra, e_ra);
        chk("ram_din", ram_din, e_din);
        ev = (rq.size() > 0) && (rq[0].due == cycle);
        chk("rvalid", rvalid, ev);
        if (ev) begin
            chk("rid", rid, rq[0].id);
            chk("rdata", rdata, rq[0].data);
            void'(rq.pop_front());
        end
        gk = -1;
        eg = '0;
        if (!rst) begin
            for (int i = 0; i < NCLI; i++) begin
                c = (mptr + i) % NCLI;
                if (gk < 0 && req[c]) gk = c;
            end
        end
        if (gk >= 0) eg[gk] = 1'b1;
        chk("gnt", gnt, eg);
        if (rst) begin
            mptr = 0;
            e_wr = 0; e_rd = 0; e_wa = 0; e_ra = 0; e_din = 0;
            for (int i = 0; i < DEP; i++) mmem[i] = '0;
            rq.delete();
        end else begin
            e_wr = 0;
            e_rd = 0;
            if (gk >= 0) begin
                mptr = (gk + 1) % NCLI;
                if (we[gk]) begin
                    e_wr  = 1;
                    e_wa  = addr[gk*ADD +: ADD];
                    e_din = wdata[gk*WI +: WI];
                    mmem[e_wa] = e_din;
                end else begin
                    e_rd = 1;
                    e_ra = addr[gk*ADD +: ADD];
                    rq.push_back('{due: cycle + 2, id: gk, data: mmem[e_ra]});
                end
            end
        end
    end

    task automatic set_op(input int k, input logic w, input logic [ADD-1:0] a, input logic [WI-1:0] d);
        we[k] = w;
        addr[k*ADD +: ADD] = a;
        wdata[k*WI +: WI] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCLI-1:0] g;
        rst = 1'b1; req = '1; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < DEP; i++) mmem[i] = '0;

        // reset with every client requesting
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_ram_wr", ram_wr, 0);
            chk("rst_ram_rd", ram_rd, 0);
            chk("rst_rvalid", rvalid, 0);
        end
        tick(); rst = 1'b0;
        @(negedge clk); chk("first_gnt", gnt, 4'b0001);

        // client 2 writes 0xA5 to addr 3, then reads it back
        tick(); req = 4'b0100; set_op(2, 1'b1, 4'd3, 8'hA5);
        @(negedge clk); chk("wr_gnt", gnt, 4'b0100);
        tick(); set_op(2, 1'b0, 4'd3, 8'h00);
        @(negedge clk); chk("rd_gnt", gnt, 4'b0100);
        chk("wr_strobe", ram_wr, 1); chk("wr_wa", ram_wa, 3); chk("wr_din", ram_din, 8'hA5);
        tick(); req = '0;
        @(negedge clk); chk("rd_strobe", ram_rd, 1); chk("rd_ra", ram_ra, 3);
        tick(); req = 4'b1000; set_op(3, 1'b1, 4'd15, 8'h55);
        @(negedge clk); chk("rd_rvalid", rvalid, 1); chk("rd_rid", rid, 2); chk("rd_rdata", rdata, 8'hA5);
        chk("c3_gnt", gnt, 4'b1000);

        // fairness: all clients hold requests
        for (int i = 0; i < NCLI; i++) set_op(i, 1'b1, 4'(8 + i), 8'(8'h10 + i));
        begin
            logic [NCLI-1:0] seq [5];
            seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            for (int s = 0; s < 5; s++) begin
                tick(); req = '1;
                @(negedge clk); chk("fair_gnt", gnt, seq[s]);
            end
        end

        // pointer skip: only clients 1 and 3
        begin
            logic [NCLI-1:0] seq [3];
            seq = '{4'b0010, 4'b1000, 4'b0010};
            for (int s = 0; s < 3; s++) begin
                tick(); req = 4'b1010;
                @(negedge clk); chk("skip_gnt", gnt, seq[s]);
            end
        end

        // write-then-read hazard on addr 7
        tick(); req = 4'b0001; set_op(0, 1'b1, 4'd7, 8'h3C);
        @(negedge clk); chk("hz_wgnt", gnt, 4'b0001);
        tick(); req = 4'b0010; set_op(1, 1'b0, 4'd7, 8'h00);
        @(negedge clk); chk("hz_rgnt", gnt, 4'b0010);
        tick(); req = '0;
        tick();
        @(negedge clk); chk("hz_rvalid", rvalid, 1); chk("hz_rid", rid, 1); chk("hz_rdata", rdata, 8'h3C);

        // reset the cycle after a read grant
        tick(); req = 4'b0100; set_op(2, 1'b0, 4'd3, 8'h00);
        @(negedge clk); chk("mr_gnt", gnt, 4'b0100);
        tick(); req = '0; rst = 1'b1;
        @(negedge clk); chk("mr_rvalid0", rvalid, 0);
        tick(); rst = 1'b0;
        @(negedge clk); chk("mr_rvalid1", rvalid, 0);
        tick();
        @(negedge clk); chk("mr_rvalid2", rvalid, 0);
        tick(); req = 4'b0100;
        @(negedge clk); chk("mr_regnt", gnt, 4'b0100);
        tick(); req = '0;
        tick();
        @(negedge clk); chk("mr_rvalid", rvalid, 1); chk("mr_rid", rid, 2); chk("mr_rdata", rdata, 0);

        // randomized traffic, requests held until granted
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); g = gnt;
            tick();
            rst = ($urandom_range(0, 249) == 0);
            for (int k = 0; k < NCLI; k++) begin
                if (g[k] || !req[k]) begin
                    req[k] = ($urandom_range(0, 3) != 0);
                    set_op(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
                end
            end
        end
        tick(); req = '0; rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_rr_arbiter.md
# ram_rr_arbiter

Round-robin access controller that shares one dual-port synchronous RAM (single write port, single read port, registered read data, synchronous clear) among NCLI requesters. Each cycle it grants at most one request, read or write, because the RAM rejects simultaneous write+read. It drives the RAM control/address/data pins from registers and returns read data tagged with the requester's index. It sits between client engines and the RAM instance.

## Interface
- NCLI, 4: number of clients (2..8)
- WI, 8: data width
- DEP, 16: RAM depth
- ADD, 4: address width, DEP = 2**ADD
- IDW, 2: client index width, clog2(NCLI)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NCLI  per-client request, held until granted
- we  in  NCLI  per-client op: 1 write, 0 read
- addr  in  NCLI*ADD  per-client address, client i at [i*ADD +: ADD]
- wdata  in  NCLI*WI  per-client write data, client i at [i*WI +: WI]
- gnt  out  NCLI  one-hot grant pulse, combinational
- rvalid  out  1  read data valid
- rid  out  IDW  client index owning rdata
- rdata  out  WI  read data, wired from ram_dout
- ram_wr, ram_rd  out  1  RAM write / read strobes, registered
- ram_wa, ram_ra  out  ADD  RAM write / read address, registered
- ram_din  out  WI  RAM write data, registered
- ram_dout  in  WI  RAM registered read data

## Operation
- Priority pointer ptr (IDW bits). Client ptr has highest priority, then ptr+1, … wrapping modulo NCLI.
- gnt = one-hot of the first requesting client from ptr. gnt is all-zero when no req or rst=1.
- The request stays asserted until gnt. Operands are sampled in the gnt cycle, and the client may change them the next cycle.
- On grant to client k: ptr <= (k+1) mod NCLI. Without a grant, ptr holds.
- Granted write: ram_wr<=1, ram_rd<=0, ram_wa<=addr[k], ram_din<=wdata[k].
- Granted read: ram_rd<=1, ram_wr<=0, ram_ra<=addr[k], and tag k is pushed into a 2-stage pipe.
- No grant: ram_wr<=0, ram_rd<=0. Address and data registers hold.
- ram_wr and ram_rd are never both 1.
- Read return: rvalid<=1 and rid<=k one cycle after ram_rd was high. rdata = ram_dout.
- Reset values: ptr 0, ram_wr 0, ram_rd 0, ram_wa 0, ram_ra 0, ram_din 0, rvalid 0, rid 0, tag pipe cleared.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced for them. The RAM clears on the same rst.
- Non-power-of-2 NCLI: ptr wraps from NCLI-1 to 0.

## Timing
- Grant is in cycle T, combinational from req and ptr.
- Write: RAM strobe visible in T+1, and memory is updated at the end of T+1.
- Read: ram_rd in T+1, ram_dout valid in T+2, rvalid/rid/rdata in T+2. Read latency is 2 cycles from grant.
- Throughput: one op per cycle, with back-to-back grants to different or the same client.
- Hazard: a write granted at T and a read of the same address granted at T+1 returns the new data.
- A client with req held continuously waits at most NCLI-1 cycles for gnt.

## Structure
- The shared package holds the op encoding constants (OP_RD=0, OP_WR=1) and a clog2 function for IDW.
- Natural sub-module: rr_arb. It holds the ptr register, performs the rotate-priority-encode, and outputs one-hot gnt plus the encoded index.
- The top level contains the operand mux, RAM-pin registers and read tag pipe.

## Test plan
- Reset: assert rst for 2 cycles with all req=1 -> gnt=0, ram_wr=ram_rd=0, rvalid=0. The first grant after release goes to client 0.
- Single write/read: client 2 writes 0xA5 to addr 3, then reads addr 3 -> ram_wr in T+1 with wa=3. rvalid in read-grant+2 with rid=2, rdata=0xA5.
- Fairness: all 4 clients hold req -> gnt sequence 0,1,2,3,0, one per cycle, never two bits set.
- Pointer skip: only clients 1 and 3 request after a grant to 1 -> next gnt=3, then 1.
- Write→read hazard: client 0 writes 0x3C to addr 7 at T, client 1 reads addr 7 at T+1 -> rvalid at T+3, rid=1, rdata=0x3C.
- Reset mid-read: rst asserted the cycle after a read grant -> no rvalid. Memory reads back 0 after release.
